// File: rtl/acc_pkg.sv
// acc_pkg: accelerator C-channel request/response payload types
// and the port-index width helper shared by the C-channel arbiter.
package acc_pkg;

  localparam int unsigned AccDataW = 32;

  typedef struct packed {
    logic [31:0]               addr;
    logic [31:0]               instr_data;
    logic [2:0][AccDataW-1:0]  rs;
    logic [31:0]               hart_id;
  } acc_c_q_t;

  typedef struct packed {
    logic [AccDataW-1:0] data;
    logic                error;
    logic                dualwb;
    logic [4:0]          rd;
    logic [31:0]         hart_id;
  } acc_c_p_t;

  // AccArbIdxW: $clog2(NumReq), never narrower than one bit
  function automatic int unsigned acc_arb_idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_c_arb_fifo.sv
// acc_c_arb_fifo: in-order FIFO of granted port indices.
// Ports: push_i/data_i write, pop_i read, full_o/empty_o, head_o, count_o.
module acc_c_arb_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_en;
  logic             pop_en;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  // a full FIFO never accepts a push, even alongside a pop
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_en) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(push_en) - CntW'(pop_en);
    end
  end

endmodule

// File: rtl/acc_c_arbiter.sv
// acc_c_arbiter: shares one accelerator C-channel among NumReq ports.
// Ports: req_q_* per-port requests, req_p_* per-port responses,
// acc_q_*/acc_p_* shared channel, outstanding_o in-flight count,
// resp_err_o sticky "response with nothing in flight".
// ACC_C_ARB_RR_EN defined: round-robin; undefined: lowest index wins.
module acc_c_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned DataWidth      = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_q_valid_i,
  output logic [NumReq-1:0]             req_q_ready_o,
  input  acc_c_q_t [NumReq-1:0]         req_q_t_i,
  output logic [NumReq-1:0]             req_p_valid_o,
  input  logic [NumReq-1:0]             req_p_ready_i,
  output acc_c_p_t [NumReq-1:0]         req_p_t_o,
  output logic                          acc_q_valid_o,
  input  logic                          acc_q_ready_i,
  output acc_c_q_t                      acc_q_t_o,
  input  logic                          acc_p_valid_i,
  output logic                          acc_p_ready_o,
  input  acc_c_p_t                      acc_p_t_i,
  output logic [$clog2(MaxOutstanding):0] outstanding_o,
  output logic                          resp_err_o
);

  localparam int unsigned IdxW = acc_arb_idx_w(NumReq);

  if (DataWidth != AccDataW) begin : g_dw_chk
    $error("DataWidth must match acc_pkg::AccDataW");
  end

  logic                 full;
  logic                 empty;
  logic [IdxW-1:0]      head;
  logic [NumReq-1:0]    elig;
  logic                 arb_any;
  logic [IdxW-1:0]      arb_idx;
  logic [IdxW-1:0]      grant;
  logic                 q_hs;
  logic                 p_hs;
  logic                 lock_q;
  logic [IdxW-1:0]      grant_idx_q;
  logic                 err_q;

  // full comes from registered count only, so the response side
  // never reaches acc_q_valid_o combinationally
  assign elig = req_q_valid_i & {NumReq{~full}};

`ifdef ACC_C_ARB_RR_EN
  logic [IdxW-1:0] rr_ptr_q;

  always_comb begin
    int unsigned k;
    arb_any = 1'b0;
    arb_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      k = (32'(rr_ptr_q) + i) % NumReq;
      if (!arb_any && elig[IdxW'(k)]) begin
        arb_any = 1'b1;
        arb_idx = IdxW'(k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (q_hs) begin
      rr_ptr_q <= IdxW'((32'(grant) + 32'd1) % NumReq);
    end
  end
`else
  always_comb begin
    arb_any = 1'b0;
    arb_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!arb_any && elig[IdxW'(i)]) begin
        arb_any = 1'b1;
        arb_idx = IdxW'(i);
      end
    end
  end
`endif

  // a stalled grant is frozen until its handshake
  assign grant         = lock_q ? grant_idx_q : arb_idx;
  assign acc_q_valid_o = rst_ni & (lock_q | arb_any);
  assign acc_q_t_o     = rst_ni ? req_q_t_i[grant] : '0;
  assign q_hs          = acc_q_valid_o & acc_q_ready_i;

  always_comb begin
    req_q_ready_o = '0;
    if (q_hs) req_q_ready_o[grant] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q      <= 1'b0;
      grant_idx_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (q_hs) begin
        lock_q <= 1'b0;
      end else if (acc_q_valid_o) begin
        lock_q      <= 1'b1;
        grant_idx_q <= grant;
      end
      if (acc_p_valid_i && empty) err_q <= 1'b1;
    end
  end

  // responses route to the FIFO head; nothing routes when empty
  assign acc_p_ready_o = ~empty & req_p_ready_i[head];
  assign p_hs          = acc_p_valid_i & acc_p_ready_o;
  assign resp_err_o    = err_q;

  always_comb begin
    req_p_valid_o = '0;
    if (acc_p_valid_i && !empty) req_p_valid_o[head] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      req_p_t_o[i] = rst_ni ? acc_p_t_i : '0;
    end
  end

  acc_c_arb_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (q_hs),
    .data_i  (grant),
    .pop_i   (p_hs),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_acc_c_arbiter.sv
// tb_acc_c_arbiter: directed bench with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_acc_c_arbiter;
  import acc_pkg::*;

  localparam int NREQ = 2;
  localparam int MAXO = 4;
`ifdef ACC_C_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [1:0]      vq;
  logic [1:0]      q_rdy;
  acc_c_q_t [1:0]  qt;
  logic [1:0]      p_val;
  logic [1:0]      p_rdy;
  acc_c_p_t [1:0]  p_t;
  logic            aq_val;
  logic            aq_rdy;
  acc_c_q_t        aq_t;
  logic            ap_val;
  logic            ap_rdy;
  acc_c_p_t        ap_t;
  logic [2:0]      outst;
  logic            rerr;

  int checks = 0;
  int errors = 0;

  acc_c_arbiter #(
    .NumReq(NREQ), .MaxOutstanding(MAXO), .DataWidth(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_q_valid_i(vq), .req_q_ready_o(q_rdy), .req_q_t_i(qt),
    .req_p_valid_o(p_val), .req_p_ready_i(p_rdy), .req_p_t_o(p_t),
    .acc_q_valid_o(aq_val), .acc_q_ready_i(aq_rdy), .acc_q_t_o(aq_t),
    .acc_p_valid_i(ap_val), .acc_p_ready_o(ap_rdy), .acc_p_t_i(ap_t),
    .outstanding_o(outst), .resp_err_o(rerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic acc_c_q_t mk_q(input int p);
    acc_c_q_t q;
    q.addr       = 32'h1000_0000 + 32'(p);
    q.instr_data = 32'h0000_A000 + 32'(p);
    q.rs[0]      = 32'h1111_0000 + 32'(p);
    q.rs[1]      = 32'h2222_0000 + 32'(p);
    q.rs[2]      = 32'h3333_0000 + 32'(p);
    q.hart_id    = 32'(p);
    return q;
  endfunction

  function automatic acc_c_q_t rnd_q();
    acc_c_q_t q;
    q.addr       = $urandom;
    q.instr_data = $urandom;
    q.rs[0]      = $urandom;
    q.rs[1]      = $urandom;
    q.rs[2]      = $urandom;
    q.hart_id    = $urandom;
    return q;
  endfunction

  function automatic acc_c_p_t rnd_p();
    acc_c_p_t p;
    p.data    = $urandom;
    p.error   = 1'($urandom);
    p.dualwb  = 1'($urandom);
    p.rd      = 5'($urandom);
    p.hart_id = $urandom;
    return p;
  endfunction

  // ---------------- reference model ----------------
  int route_q[$];
  bit m_lock;
  int m_lock_port;
  int m_rr;
  bit m_err;

  always @(negedge clk) begin
    int gnt;
    int h;
    bit ev;
    bit full;
    logic [1:0] e_rdy;
    logic [1:0] e_pv;
    logic e_pr;
    if (!rst_n) begin
      chk("rst_aq_val", 256'(aq_val), 256'(0));
      chk("rst_q_rdy", 256'(q_rdy), 256'(0));
      chk("rst_aq_t", 256'(aq_t), 256'(0));
      chk("rst_p_val", 256'(p_val), 256'(0));
      chk("rst_ap_rdy", 256'(ap_rdy), 256'(0));
      chk("rst_p_t", 256'(p_t), 256'(0));
      chk("rst_outst", 256'(outst), 256'(0));
      chk("rst_rerr", 256'(rerr), 256'(0));
      route_q.delete();
      m_lock = 0;
      m_lock_port = 0;
      m_rr = 0;
      m_err = 0;
    end else begin
      full = (route_q.size() >= MAXO);
      gnt = -1;
      if (m_lock) gnt = m_lock_port;
      else if (!full)
        for (int j = 0; j < NREQ; j++) begin
          int p;
          p = RR ? (m_rr + j) % NREQ : j;
          if (gnt < 0 && vq[p]) gnt = p;
        end
      ev = (gnt >= 0);
      chk("m_aq_val", 256'(aq_val), 256'(ev));
      if (ev) chk("m_aq_t", 256'(aq_t), 256'(qt[gnt]));
      e_rdy = (ev && aq_rdy) ? 2'(1 << gnt) : 2'b00;
      chk("m_q_rdy", 256'(q_rdy), 256'(e_rdy));
      if (route_q.size() == 0) begin
        e_pv = 2'b00;
        e_pr = 1'b0;
      end else begin
        h = route_q[0];
        e_pv = ap_val ? 2'(1 << h) : 2'b00;
        e_pr = p_rdy[h];
      end
      chk("m_p_val", 256'(p_val), 256'(e_pv));
      chk("m_ap_rdy", 256'(ap_rdy), 256'(e_pr));
      for (int i = 0; i < NREQ; i++)
        chk("m_p_t", 256'(p_t[i]), 256'(ap_t));
      chk("m_outst", 256'(outst), 256'(route_q.size()));
      chk("m_rerr", 256'(rerr), 256'(m_err));
      if (ap_val && route_q.size() == 0) m_err = 1;
      if (ap_val && e_pr) void'(route_q.pop_front());
      if (ev && aq_rdy) begin
        route_q.push_back(gnt);
        m_rr = (gnt + 1) % NREQ;
        m_lock = 0;
      end else if (ev) begin
        m_lock = 1;
        m_lock_port = gnt;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    ap_t = rnd_p();
  endtask

  task automatic idle();
    vq = 2'b00;
    aq_rdy = 1'b0;
    ap_val = 1'b0;
    p_rdy = 2'b00;
    qt[0] = mk_q(0);
    qt[1] = mk_q(1);
  endtask

  task automatic rnd_in();
    vq = 2'($urandom);
    aq_rdy = 1'($urandom);
    ap_val = 1'($urandom);
    p_rdy = 2'($urandom);
    qt[0] = rnd_q();
    qt[1] = rnd_q();
  endtask

  logic [1:0] seq_a [4];

  initial begin
    rst_n = 1'b0;
    ap_t = rnd_p();
    rnd_in();
    // 1. reset with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_lit_val", 256'(aq_val), 256'(0));
      tick();
      rnd_in();
    end
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_outst", 256'(outst), 256'(0));
    tick();

    // 2. both ports valid, accelerator ready: fill the FIFO
    seq_a[0] = 2'b01;
    seq_a[1] = RR ? 2'b10 : 2'b01;
    seq_a[2] = 2'b01;
    seq_a[3] = RR ? 2'b10 : 2'b01;
    vq = 2'b11;
    aq_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_grant", 256'(q_rdy), 256'(seq_a[i]));
      tick();
    end
    // full: fifth request stalls
    @(negedge clk);
    chk("full_val", 256'(aq_val), 256'(0));
    chk("full_outst", 256'(outst), 256'(4));
    tick();
    // responses return in grant order
    vq = 2'b00;
    ap_val = 1'b1;
    p_rdy = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_resp", 256'(p_val), 256'(seq_a[i]));
      tick();
    end
    ap_val = 1'b0;
    @(negedge clk);
    chk("drain_outst", 256'(outst), 256'(0));
    tick();

    // 4. full then one pop -> granted next cycle
    vq = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    ap_val = 1'b1;
    @(negedge clk);
    chk("pop_stall", 256'(aq_val), 256'(0));
    chk("pop_head", 256'(p_val), 256'(2'b01));
    tick();
    ap_val = 1'b0;
    @(negedge clk);
    chk("pop_regrant", 256'(aq_val), 256'(1));
    chk("pop_rdy", 256'(q_rdy), 256'(2'b01));
    chk("pop_outst", 256'(outst), 256'(3));
    tick();
    vq = 2'b00;
    ap_val = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ap_val = 1'b0;

    // 3. lock: port 1 stalled while port 0 raises valid
    vq = 2'b10;
    aq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lock_val", 256'(aq_val), 256'(1));
      chk("lock_t", 256'(aq_t), 256'(mk_q(1)));
      chk("lock_rdy", 256'(q_rdy), 256'(0));
      tick();
      vq = 2'b11;
    end
    aq_rdy = 1'b1;
    @(negedge clk);
    chk("lock_hs", 256'(q_rdy), 256'(2'b10));
    tick();
    @(negedge clk);
    chk("lock_next", 256'(q_rdy), 256'(2'b01));
    tick();
    vq = 2'b00;
    ap_val = 1'b1;
    @(negedge clk);
    chk("lock_resp1", 256'(p_val), 256'(2'b10));
    tick();
    @(negedge clk);
    chk("lock_resp0", 256'(p_val), 256'(2'b01));
    tick();
    ap_val = 1'b0;

    // 5. response backpressure on the head port
    vq = 2'b10;
    tick();
    vq = 2'b00;
    ap_val = 1'b1;
    p_rdy = 2'b01;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_ardy", 256'(ap_rdy), 256'(0));
      chk("bp_pval", 256'(p_val), 256'(2'b10));
      chk("bp_outst", 256'(outst), 256'(1));
      tick();
    end
    p_rdy = 2'b11;
    @(negedge clk);
    chk("bp_release", 256'(ap_rdy), 256'(1));
    tick();
    ap_val = 1'b0;
    @(negedge clk);
    chk("bp_outst0", 256'(outst), 256'(0));
    tick();

    // simultaneous push and pop while not full
    vq = 2'b01;
    tick();
    ap_val = 1'b1;
    @(negedge clk);
    chk("pp_outst", 256'(outst), 256'(1));
    tick();
    vq = 2'b00;
    ap_val = 1'b0;
    @(negedge clk);
    chk("pp_outst_after", 256'(outst), 256'(1));
    tick();
    ap_val = 1'b1;
    tick();
    ap_val = 1'b0;
    tick();

    // 6. spurious response with FIFO empty
    ap_val = 1'b1;
    @(negedge clk);
    chk("sp_ardy", 256'(ap_rdy), 256'(0));
    chk("sp_pval", 256'(p_val), 256'(0));
    chk("sp_err0", 256'(rerr), 256'(0));
    tick();
    ap_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sp_err_sticky", 256'(rerr), 256'(1));
      tick();
    end

    // reset mid-operation
    vq = 2'b11;
    tick();
    tick();
    rst_n = 1'b0;
    rnd_in();
    for (int i = 0; i < 3; i++) tick();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_outst", 256'(outst), 256'(0));
    chk("mid_rst_err", 256'(rerr), 256'(0));
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
